// File: rtl/pwm_level_ctrl.sv
// pwm_level_ctrl: debounced up/down buttons step a saturating 4-bit duty level. Rev 1.0
// Optional hold-to-repeat stepping is enabled by defining PWM_LEVEL_AUTO_REPEAT_EN.
`default_nettype none

module pwm_level_ctrl #(
  parameter int         DB_CYCLES     = 500000,
  parameter logic [3:0] W_INIT        = 4'd0,
  parameter int         REPEAT_DELAY  = 25000000,
  parameter int         REPEAT_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_dn,
  output logic [3:0] w,
  output logic       changed
);

  localparam int CW = $clog2(DB_CYCLES);

  logic [1:0] raw;
  logic [1:0] stable;
  logic [1:0] press;
  logic [1:0] step;
  logic       up_step;
  logic       dn_step;

  // Bit 0 is the up button, bit 1 the down button.
  assign raw = {btn_dn, btn_up};

  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic          sync1;
    logic          sync2;
    logic          st;
    logic          st_d;
    logic          pr;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
        st    <= 1'b0;
        st_d  <= 1'b0;
        pr    <= 1'b0;
        cnt   <= '0;
      end else begin
        sync1 <= raw[i];
        sync2 <= sync1;
        if (sync2 == st) begin
          cnt <= '0;
        end else if (cnt == CW'(DB_CYCLES - 1)) begin
          st  <= ~st;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        st_d <= st;
        pr   <= st & ~st_d;
      end
    end

    assign stable[i] = st;
    assign press[i]  = pr;
  end

`ifdef PWM_LEVEL_AUTO_REPEAT_EN
  localparam int HMAX = (REPEAT_DELAY > REPEAT_CYCLES) ? REPEAT_DELAY : REPEAT_CYCLES;
  localparam int HW   = $clog2(HMAX + 1);

  logic [HW-1:0] hold_cnt;
  logic          hold_phase;
  logic [1:0]    rep;
  logic          one_held;
  logic          fire;

  // Counter starts with the debounced press, so the first repeat lands
  // REPEAT_DELAY cycles after the press step reaches w.
  assign one_held = stable[0] ^ stable[1];
  assign fire     = hold_phase ? (hold_cnt == HW'(REPEAT_CYCLES))
                               : (hold_cnt == HW'(REPEAT_DELAY));

  always_ff @(posedge clk) begin
    if (rst || !one_held) begin
      hold_cnt   <= '0;
      hold_phase <= 1'b0;
      rep        <= 2'b00;
    end else if (fire) begin
      hold_cnt   <= HW'(1);
      hold_phase <= 1'b1;
      rep        <= stable;
    end else begin
      hold_cnt   <= hold_cnt + 1'b1;
      rep        <= 2'b00;
    end
  end

  assign step = press | rep;
`else
  assign step = press;
`endif

  assign up_step = step[0] & ~step[1];
  assign dn_step = step[1] & ~step[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      w       <= W_INIT;
      changed <= 1'b0;
    end else begin
      changed <= 1'b0;
      if (up_step && (w != 4'd15)) begin
        w       <= w + 4'd1;
        changed <= 1'b1;
      end else if (dn_step && (w != 4'd0)) begin
        w       <= w - 4'd1;
        changed <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pwm_level_ctrl.sv
// tb_pwm_level_ctrl: directed self-checking bench for pwm_level_ctrl. Rev 1.0
`default_nettype none

module tb_pwm_level_ctrl;

  localparam int DB = 4;
`ifdef PWM_LEVEL_AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_dn = 1'b0;
  logic [3:0] w;
  logic       changed;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  pwm_level_ctrl #(
    .DB_CYCLES    (DB),
    .W_INIT       (4'd2),
    .REPEAT_DELAY (20),
    .REPEAT_CYCLES(8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_up (btn_up),
    .btn_dn (btn_dn),
    .w      (w),
    .changed(changed)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (changed) pulses++;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_btn(input bit up);
    if (up) btn_up = 1'b1; else btn_dn = 1'b1;
    edges(12);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    edges(12);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    edges(2);
    rst = 1'b0;
  endtask

  function automatic int exp_w6(input int e);
    int v = 10;
    if (e >= 7) v--;
    if (AR) begin
      if (e >= 27) v--;
      for (int t = 35; t <= 59; t += 8) if (e >= t) v--;
    end
    return v;
  endfunction

  initial begin
    // 1: reset
    edges(2);
    check("rst_w", w, 2);
    check("rst_changed", changed, 0);
    check("rst_pulses", pulses, 0);
    rst = 1'b0;
    edges(3);
    check("idle_w", w, 2);

    // 2: single up press, latency DB+3
    pulses = 0;
    btn_up = 1'b1;
    edges(7);
    check("lat_before_w", w, 2);
    edges(1);
    check("lat_w", w, 3);
    check("lat_changed", changed, 1);
    edges(1);
    check("lat_changed_drop", changed, 0);
    edges(3);
    btn_up = 1'b0;
    edges(20);
    check("t2_final_w", w, 3);
    check("t2_pulses", pulses, 1);

    // 3: glitches shorter than the debounce window
    do_reset();
    check("t3_rst_w", w, 2);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      btn_up = 1'b1;
      edges(3);
      btn_up = 1'b0;
      edges(1);
    end
    edges(10);
    check("glitch_w", w, 2);
    check("glitch_pulses", pulses, 0);

    // 4: saturation at 15 and at 0
    for (int k = 0; k < 12; k++) press_btn(1'b1);
    check("t4_w14", w, 14);
    pulses = 0;
    press_btn(1'b1);
    check("sat_hi_first_w", w, 15);
    check("sat_hi_first_pulses", pulses, 1);
    press_btn(1'b1);
    press_btn(1'b1);
    check("sat_hi_w", w, 15);
    check("sat_hi_pulses", pulses, 1);
    do_reset();
    press_btn(1'b0);
    press_btn(1'b0);
    check("t4_w0", w, 0);
    pulses = 0;
    press_btn(1'b0);
    check("sat_lo_w", w, 0);
    check("sat_lo_pulses", pulses, 0);

    // 5: simultaneous presses, then reset mid-debounce
    press_btn(1'b1);
    press_btn(1'b1);
    check("t5_start_w", w, 2);
    pulses = 0;
    btn_up = 1'b1;
    btn_dn = 1'b1;
    edges(12);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    edges(12);
    check("both_w", w, 2);
    check("both_pulses", pulses, 0);
    press_btn(1'b1);
    press_btn(1'b1);
    check("t5_pre_rst_w", w, 4);
    btn_up = 1'b1;
    edges(4);
    rst = 1'b1;
    edges(1);
    rst = 1'b0;
    check("mid_rst_w", w, 2);
    pulses = 0;
    edges(7);
    check("mid_rst_before_w", w, 2);
    check("mid_rst_before_pulses", pulses, 0);
    edges(1);
    check("mid_rst_w_step", w, 3);
    check("mid_rst_changed", changed, 1);
    edges(4);
    btn_up = 1'b0;
    edges(12);

    // 6: long hold of the down button from w=10
    for (int k = 0; k < 7; k++) press_btn(1'b1);
    check("t6_start_w", w, 10);
    pulses = 0;
    btn_dn = 1'b1;
    for (int e = 0; e < 60; e++) begin
      edges(1);
      check($sformatf("hold_w_e%0d", e), w, exp_w6(e));
    end
    btn_dn = 1'b0;
    edges(20);
    check("hold_final_w", w, AR ? 4 : 9);
    check("hold_pulses", pulses, AR ? 6 : 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
